regfile_scan_reader: RTL and testbench

Read-side initiator for the lab register file. The write side loads the register file with save_data and write_en. This block drives the same file's read port (show_reg, address on d_in, data on d_out) and walks a contiguous address range. Each register value is emitted on a valid/ready output stream tagged with its address, for display logic or a host bridge.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_scan_reader_if.sv | 30 +++
 rtl/regfile_scan_reader_read_port.sv | 28 ++
 rtl/regfile_scan_reader.sv | 115 +++++++++++
 tb/tb_regfile_scan_reader.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the lab register file and its read-side scanner.
// Holds default bus widths and the scanner FSM state type.
package regfile_pkg;

    localparam int RF_AW = 8;
    localparam int RF_DW = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        PRESENT = 2'd2,
        FINISH  = 2'd3
    } scan_state_e;

endpackage

// File: rtl/regfile_scan_reader_if.sv
// Address-tagged valid/ready output stream of the register-file scanner.
// master: drives out_valid/out_addr/out_data/out_last, receives out_ready.
interface regfile_scan_reader_if #(
    parameter int AW = 8,
    parameter int DW = 8
);

    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/regfile_scan_reader_read_port.sv
// rf_read_port_ctrl: counts cycles the read port has been held and raises
// capture in the READ_LAT-th cycle. Ports: clk, rst, active (in REQ), capture.
module rf_read_port_ctrl #(
    parameter int READ_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    output logic capture
);

    logic [2:0] wait_cnt;

    assign capture = active && (wait_cnt == 3'(READ_LAT - 1));

    // Counter restarts every time the port is released, so each
    // new request gets a full READ_LAT hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (!active || capture) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/regfile_scan_reader.sv
// Walks a contiguous register-file address range through the read port and
// streams each value tagged with its address. Ports: clk, rst, start,
// first_addr, count, abort, rf_show/rf_addr/rf_data, out (stream), busy, done.
module regfile_scan_reader
    import regfile_pkg::*;
#(
    parameter int AW       = RF_AW,
    parameter int DW       = RF_DW,
    parameter int READ_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [AW-1:0]         first_addr,
    input  logic [AW:0]           count,
    input  logic                  abort,
    output logic                  rf_show,
    output logic [AW-1:0]         rf_addr,
    input  logic [DW-1:0]         rf_data,
    regfile_scan_reader_if.master out,
    output logic                  busy,
    output logic                  done
);

    scan_state_e   state;
    logic [AW:0]   remain;
    logic          capture;
    logic          o_valid;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_last;

    rf_read_port_ctrl #(
        .READ_LAT (READ_LAT)
    ) u_port (
        .clk     (clk),
        .rst     (rst),
        .active  (state == REQ),
        .capture (capture)
    );

    assign out.out_valid = o_valid;
    assign out.out_addr  = o_addr;
    assign out.out_data  = o_data;
    assign out.out_last  = o_last;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            remain  <= '0;
            rf_show <= 1'b0;
            rf_addr <= '0;
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_data  <= '0;
            o_last  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rf_addr <= first_addr;
                        remain  <= count;
                        if (count == '0) begin
                            state <= FINISH;
                        end else begin
                            state   <= REQ;
                            rf_show <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    // abort outranks a capture landing on the same edge
                    if (abort) begin
                        state   <= IDLE;
                        rf_show <= 1'b0;
                    end else if (capture) begin
                        o_data  <= rf_data;
                        o_addr  <= rf_addr;
                        o_valid <= 1'b1;
                        o_last  <= (remain == (AW+1)'(1));
                        rf_show <= 1'b0;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (abort) begin
                        o_valid <= 1'b0;
                        o_last  <= 1'b0;
                        state   <= IDLE;
                    end else if (out.out_ready) begin
                        o_valid <= 1'b0;
                        if (o_last) begin
                            state <= FINISH;
                        end else begin
                            rf_addr <= rf_addr + 1'b1;
                            remain  <= remain - 1'b1;
                            rf_show <= 1'b1;
                            state   <= REQ;
                        end
                    end
                end
                FINISH: begin
                    done   <= 1'b1;
                    o_last <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_scan_reader.sv
// Scoreboard bench for regfile_scan_reader: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted stream word.
module tb_regfile_scan_reader;
    import regfile_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW:0]   count;
    logic          abort;
    logic          rf_show;
    logic [AW-1:0] rf_addr;
    logic [DW-1:0] rf_data;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    regfile_scan_reader_if #(.AW(AW), .DW(DW)) sif ();

    regfile_scan_reader #(
        .AW       (AW),
        .DW       (DW),
        .READ_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .count      (count),
        .abort      (abort),
        .rf_show    (rf_show),
        .rf_addr    (rf_addr),
        .rf_data    (rf_data),
        .out        (sif),
        .busy       (busy),
        .done       (done)
    );

    // Register file model: d_out is only correct once show_reg/d_in have
    // been held LAT cycles; before that it returns the inverted value.
    logic [DW-1:0] mem [256];
    int hold_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) hold_cnt <= 0;
        else     hold_cnt <= rf_show ? hold_cnt + 1 : 0;
    end

    assign rf_data = (rf_show && hold_cnt >= LAT - 1) ?
                     mem[rf_addr] : ~mem[rf_addr];

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   done_seen = 0;
    int   done_exp = 0;
    logic rnd_ready = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor
    logic          stall_q = 1'b0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic          pl;
    exp_t          e;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (done) done_seen++;
            if (sif.out_valid) check("show_in_present", 32'(rf_show), 0);
            if (stall_q && sif.out_valid)
                check("stall_hold",
                      {15'd0, sif.out_last, sif.out_data, sif.out_addr},
                      {15'd0, pl, pd, pa});
            if (sif.out_valid && sif.out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("word",
                          {15'd0, sif.out_last, sif.out_data, sif.out_addr},
                          {15'd0, e.l, e.d, e.a});
                end
            end
            stall_q = sif.out_valid && !sif.out_ready;
            pa = sif.out_addr;
            pd = sif.out_data;
            pl = sif.out_last;
        end
    end

    initial begin
        sif.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_ready) sif.out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_scan(input logic [AW-1:0] fa, input int cnt);
        logic [AW-1:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = AW'(int'(fa) + i);
            q.push_back('{a, mem[a], (i == cnt - 1)});
        end
        done_exp++;
    endtask

    task automatic pulse_start(input logic [AW-1:0] fa, input int cnt);
        first_addr = fa;
        count      = (AW+1)'(cnt);
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (!done && k < bound) begin
            tick();
            k++;
        end
        check("scan_done", 32'(done), 1);
    endtask

    task automatic wait_word(input logic [AW-1:0] a);
        int k = 0;
        while (!(sif.out_valid && sif.out_addr == a) && k < 100) begin
            tick();
            k++;
        end
        check("wait_word", 32'(sif.out_valid), 1);
    endtask

    initial begin
        int cnt;
        logic [AW-1:0] fa;

        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        first_addr = '0;
        count      = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[1] = 8'h15;
        mem[2] = 8'hA3;
        mem[3] = 8'h87;
        repeat (3) tick();
        check("rst_show", 32'(rf_show), 0);
        check("rst_valid", 32'(sif.out_valid), 0);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        check("rst_regs",
              {15'd0, sif.out_last, sif.out_data, sif.out_addr}, 0);
        rst = 1'b0;
        tick();

        // basic scan
        sif.out_ready = 1'b1;
        push_scan(8'h01, 3);
        pulse_start(8'h01, 3);
        wait_done(100);
        tick();
        check("busy_after", 32'(busy), 0);

        // stall on word 2
        push_scan(8'h01, 3);
        pulse_start(8'h01, 3);
        wait_word(8'h02);
        sif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_valid", 32'(sif.out_valid), 1);
        end
        sif.out_ready = 1'b1;
        wait_done(100);

        // wrap, plus a start while busy that must be ignored
        push_scan(8'hFE, 3);
        pulse_start(8'hFE, 3);
        tick();
        pulse_start(8'h77, 5);
        wait_done(100);

        // count = 0
        done_exp++;
        pulse_start(8'h40, 0);
        check("zero_cnt_d1", {30'd0, busy, done}, 32'b10);
        check("zero_cnt_show1", 32'(rf_show), 0);
        tick();
        check("zero_cnt_d2", {30'd0, busy, done}, 32'b01);
        check("zero_cnt_show2", 32'(rf_show), 0);
        tick();

        // abort while presenting word 2
        q.push_back('{8'h01, mem[1], 1'b0});
        pulse_start(8'h01, 3);
        wait_word(8'h02);
        sif.out_ready = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", 32'(sif.out_valid), 0);
        check("abort_busy_done", {30'd0, busy, done}, 0);
        check("abort_show", 32'(rf_show), 0);
        tick();
        check("abort_no_done", 32'(done), 0);
        sif.out_ready = 1'b1;
        push_scan(8'h03, 1);
        pulse_start(8'h03, 1);
        wait_done(100);

        // async reset mid-REQ
        pulse_start(8'h01, 3);
        check("req_show", 32'(rf_show), 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_show_addr", {23'd0, rf_show, rf_addr}, 0);
        check("arst_outs",
              {14'd0, sif.out_valid, sif.out_last,
               sif.out_data, sif.out_addr}, 0);
        check("arst_busy_done", {30'd0, busy, done}, 0);
        tick();
        rst = 1'b0;
        repeat (4) tick();
        check("post_rst_idle",
              {29'd0, busy, rf_show, sif.out_valid}, 0);

        // randomized scans with random backpressure
        rnd_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
            fa  = 8'($urandom);
            cnt = (s == 10) ? 260 : $urandom_range(0, 7);
            push_scan(fa, cnt);
            pulse_start(fa, cnt);
            wait_done((cnt + 2) * (LAT + 1) * 10 + 20);
            tick();
        end
        rnd_ready = 1'b0;
        repeat (3) tick();

        check("queue_empty", 32'(q.size()), 0);
        check("done_count", 32'(done_seen), 32'(done_exp));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
